instruction_fetch_unit: RTL and testbench

- Producer side of the 33-bit instruction word consumed by the decode/control stage.
- Holds a small program RAM and a program counter (PC).
- Fetches words, presents them on a valid/ready handshake, and resolves conditional PC-relative jumps using the cond and jump fields and the ALU flags returned by the execution unit.
- Sits between the program loader/testbench and control_unit.

---
 rtl/isa_pkg.sv | 48 ++++
 rtl/program_ram.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Instruction-word field layout, condition/flag encodings and the fetch state enum.
// Shared by the fetch unit and control_unit so encoder and decoder agree on the format.
package isa_pkg;
    localparam int RSVD_BIT   = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int COND_MSB   = 27;
    localparam int COND_LSB   = 26;
    localparam int JUMP_MSB   = 25;
    localparam int JUMP_LSB   = 23;
    localparam int LOAD_MSB   = 22;
    localparam int LOAD_LSB   = 15;
    localparam int ADDR3_MSB  = 14;
    localparam int ADDR3_LSB  = 10;
    localparam int ADDR2_MSB  = 9;
    localparam int ADDR2_LSB  = 5;
    localparam int ADDR1_MSB  = 4;
    localparam int ADDR1_LSB  = 0;

    localparam logic [1:0] COND_NEVER  = 2'b00;
    localparam logic [1:0] COND_ZERO   = 2'b01;
    localparam logic [1:0] COND_CARRY  = 2'b10;
    localparam logic [1:0] COND_ALWAYS = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_FLAGS,
        ST_HALT
    } fetch_state_e;

    function automatic logic cond_taken(input logic [1:0] cond, input logic [3:0] flag);
        case (cond)
            COND_ZERO:   cond_taken = flag[FLAG_Z];
            COND_CARRY:  cond_taken = flag[FLAG_C];
            COND_ALWAYS: cond_taken = 1'b1;
            default:     cond_taken = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/program_ram.sv
// Single-write / single-read program RAM, synchronous on both ports.
// A read of the address being written in the same cycle returns the new data.
module program_ram #(
    parameter int AW = 5,
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = mem[raddr];
        if (we && (waddr == raddr)) rdata_d = wdata;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Program RAM + PC sequencer issuing instruction words over valid/ready and resolving
// conditional PC-relative jumps. Define BACKWARD_JUMP_EN to treat jump as a signed offset.
module instruction_fetch_unit #(
    parameter int         PC_WIDTH    = 5,
    parameter int         INSTR_WIDTH = 33,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_WIDTH-1:0]    prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic [3:0]             flag,
    input  logic                   flag_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted
);
    import isa_pkg::*;

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   halted_q, halted_d;

    logic                   ram_we;
    logic [INSTR_WIDTH-1:0] ram_rdata;
    logic [PC_WIDTH-1:0]    jump_off, pc_inc, pc_tgt;
    logic [1:0]             cond;

    assign ram_we = prog_we && ((state_q == ST_IDLE) || (state_q == ST_HALT));
    assign cond   = instr_q[COND_MSB:COND_LSB];

`ifdef BACKWARD_JUMP_EN
    assign jump_off = {{(PC_WIDTH-3){instr_q[JUMP_MSB]}}, instr_q[JUMP_MSB:JUMP_LSB]};
`else
    assign jump_off = {{(PC_WIDTH-3){1'b0}}, instr_q[JUMP_MSB:JUMP_LSB]};
`endif

    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign pc_tgt = pc_inc + jump_off;

    // Read address follows the next PC so the word is ready while in FETCH.
    program_ram #(
        .AW (PC_WIDTH),
        .DW (INSTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_d),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            ST_FETCH: begin
                instr_d           = ram_rdata;
                instr_d[RSVD_BIT] = 1'b0;
                instr_valid_d     = 1'b1;
                state_d           = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (instr_q[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if ((cond == COND_ZERO) || (cond == COND_CARRY)) begin
                        state_d = ST_WAIT_FLAGS;
                    end else begin
                        pc_d    = cond_taken(cond, 4'b0000) ? pc_tgt : pc_inc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WAIT_FLAGS: begin
                if (flag_valid) begin
                    pc_d    = cond_taken(cond, flag) ? pc_tgt : pc_inc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected (pc, word) pairs are queued when
// a program is started and popped at every accepted handshake.
module tb_instruction_fetch_unit;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [32:0] prog_data = '0;
    logic [32:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [3:0]  flag = '0;
    logic        flag_valid = 1'b0;
    logic [4:0]  pc;
    logic        halted;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    typedef struct {
        logic [4:0]  pc;
        logic [32:0] w;
    } exp_t;
    exp_t sb[$];

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .flag(flag),
        .flag_valid(flag_valid), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            exp_t e;
            hs_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL hs_unexpected: got pc=%0d instr=%h, expected no handshake", pc, instr);
            end else begin
                e = sb.pop_front();
                if (pc !== e.pc || instr !== e.w) begin
                    failures++;
                    $display("FAIL hs_word: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             pc, instr, e.pc, e.w);
                end
            end
        end
    end

    function automatic logic [32:0] mk(input logic [3:0] op, input logic [1:0] c,
                                       input logic [2:0] j, input logic [7:0] ln,
                                       input logic r32);
        mk = {r32, op, c, j, ln, 5'd3, 5'd2, 5'd1};
    endfunction

    function automatic logic [32:0] clr(input logic [32:0] w);
        clr = w;
        clr[32] = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_ready = 1'b0; start = 1'b0; flag_valid = 1'b0; prog_we = 1'b0;
        tick(); tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic load(input logic [4:0] a, input logic [32:0] w);
        prog_we = 1'b1; prog_addr = a; prog_data = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [4:0] p, input logic [32:0] w);
        exp_t e;
        e.pc = p; e.w = clr(w);
        sb.push_back(e);
    endtask

    task automatic wait_halted(input string tag, output int cnt);
        cnt = 0;
        while (!halted && cnt < 200) begin tick(); cnt++; end
        if (!halted) begin
            checks++; failures++;
            $display("FAIL %s_timeout: halted=%b after %0d cycles, expected 1", tag, halted, cnt);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        if (!instr_valid) begin
            checks++; failures++;
            $display("FAIL %s_valid_timeout: instr_valid=%b, expected 1", tag, instr_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b0 || pc !== 5'd0 || instr !== 33'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b halted=%b pc=%0d instr=%h, expected 0 0 0 0",
                     instr_valid, halted, pc, instr);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [32:0] w0, w1, w2;
        int cnt;
        do_reset();
        w0 = mk(4'h1, COND_NEVER, 3'd5, 8'h12, 1'b1);
        w1 = mk(4'h2, COND_NEVER, 3'd0, 8'h34, 1'b0);
        w2 = mk(4'hF, COND_NEVER, 3'd0, 8'h56, 1'b1);
        load(0, w0); load(1, w1); load(2, w2);
        push(0, w0); push(1, w1); push(2, w2);
        instr_ready = 1'b1;
        pulse_start();
        wait_halted("basic", cnt);
        checks++;
        if (cnt !== 6) begin
            failures++;
            $display("FAIL basic_throughput: got %0d cycles to halt, expected 6", cnt);
        end
        checks++;
        if (pc !== 5'd2 || halted !== 1'b1 || instr_valid !== 1'b0 || instr[32] !== 1'b0) begin
            failures++;
            $display("FAIL basic_halt: got pc=%0d halted=%b valid=%b b32=%b, expected 2 1 0 0",
                     pc, halted, instr_valid, instr[32]);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL basic_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_jump();
        logic [32:0] w0, w4, w3;
        int cnt;
        do_reset();
        w0 = mk(4'h1, COND_ALWAYS, 3'd3, 8'h00, 1'b0);
        load(0, w0); push(0, w0);
`ifdef BACKWARD_JUMP_EN
        w4 = mk(4'h2, COND_ALWAYS, 3'b110, 8'h44, 1'b0);
        w3 = mk(4'hF, COND_NEVER, 3'd0, 8'h33, 1'b0);
        load(4, w4); load(3, w3);
        push(4, w4); push(3, w3);
`else
        w4 = mk(4'hF, COND_NEVER, 3'd0, 8'h44, 1'b0);
        w3 = '0;
        load(4, w4); push(4, w4);
`endif
        instr_ready = 1'b1;
        pulse_start();
        wait_halted("jump", cnt);
        checks++;
`ifdef BACKWARD_JUMP_EN
        if (pc !== 5'd3 || sb.size() != 0) begin
            failures++;
            $display("FAIL jump_target: got pc=%0d pending=%0d, expected 3 0", pc, sb.size());
        end
`else
        if (pc !== 5'd4 || sb.size() != 0) begin
            failures++;
            $display("FAIL jump_target: got pc=%0d pending=%0d, expected 4 0", pc, sb.size());
        end
`endif
    endtask

    task automatic test_wait_flags(input logic [1:0] c, input logic [3:0] flg,
                                   input logic [4:0] exp_pc);
        logic [32:0] w0, w1, w3;
        int cnt;
        do_reset();
        w0 = mk(4'h1, c, 3'd2, 8'h01, 1'b0);
        w1 = mk(4'hF, COND_NEVER, 3'd0, 8'h11, 1'b0);
        w3 = mk(4'hF, COND_NEVER, 3'd0, 8'h33, 1'b0);
        load(0, w0); load(1, w1); load(3, w3);
        push(0, w0); push(exp_pc, (exp_pc == 5'd3) ? w3 : w1);
        instr_ready = 1'b1;
        pulse_start();
        wait_valid("wflags");
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (instr_valid !== 1'b0 || pc !== 5'd0) begin
                failures++;
                $display("FAIL wflags_hold: cycle %0d got valid=%b pc=%0d, expected 0 0",
                         i, instr_valid, pc);
            end
        end
        flag = flg; flag_valid = 1'b1;
        tick();
        flag_valid = 1'b0; flag = '0;
        checks++;
        if (pc !== exp_pc) begin
            failures++;
            $display("FAIL wflags_pc: cond=%b flag=%b got pc=%0d, expected %0d", c, flg, pc, exp_pc);
        end
        wait_halted("wflags", cnt);
        checks++;
        if (pc !== exp_pc || sb.size() != 0) begin
            failures++;
            $display("FAIL wflags_end: got pc=%0d pending=%0d, expected %0d 0", pc, sb.size(), exp_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] w0, w1;
        int h0, cnt;
        do_reset();
        w0 = mk(4'h5, COND_NEVER, 3'd1, 8'hA5, 1'b1);
        w1 = mk(4'hF, COND_NEVER, 3'd0, 8'h5A, 1'b0);
        load(0, w0); load(1, w1);
        push(0, w0); push(1, w1);
        pulse_start();
        wait_valid("bp");
        h0 = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== clr(w0) || pc !== 5'd0) begin
                failures++;
                $display("FAIL bp_stable: cycle %0d got valid=%b instr=%h pc=%0d, expected 1 %h 0",
                         i, instr_valid, instr, pc, clr(w0));
            end
            tick();
        end
        instr_ready = 1'b1;
        wait_halted("bp", cnt);
        checks++;
        if (hs_cnt - h0 != 2) begin
            failures++;
            $display("FAIL bp_handshakes: got %0d, expected 2", hs_cnt - h0);
        end
    endtask

    task automatic test_prog_we_issue();
        logic [32:0] w0, w1;
        int cnt;
        do_reset();
        w0 = mk(4'h1, COND_NEVER, 3'd0, 8'h10, 1'b0);
        w1 = mk(4'hF, COND_NEVER, 3'd0, 8'h5A, 1'b0);
        load(0, w0); load(1, w1);
        push(0, w0); push(1, w1);
        pulse_start();
        wait_valid("we_issue");
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = mk(4'h7, COND_NEVER, 3'd0, 8'hEE, 1'b0);
        tick();
        prog_we = 1'b0;
        instr_ready = 1'b1;
        wait_halted("we_issue", cnt);
        checks++;
        if (pc !== 5'd1 || sb.size() != 0) begin
            failures++;
            $display("FAIL we_issue: got pc=%0d pending=%0d, expected 1 0", pc, sb.size());
        end
    endtask

    task automatic test_start_with_we();
        logic [32:0] wn;
        int cnt;
        do_reset();
        wn = mk(4'hF, COND_NEVER, 3'd0, 8'hC3, 1'b1);
        push(0, wn);
        instr_ready = 1'b1;
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = wn; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_halted("start_we", cnt);
        checks++;
        if (pc !== 5'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL start_we: got pc=%0d pending=%0d, expected 0 0", pc, sb.size());
        end
    endtask

    task automatic test_wrap();
        logic [32:0] w[5];
        logic [4:0]  a[5];
        int h0, n;
        do_reset();
`ifdef BACKWARD_JUMP_EN
        a = '{5'd0, 5'd29, 5'd30, 5'd31, 5'd0};
        w[0] = mk(4'h1, COND_ALWAYS, 3'b100, 8'h00, 1'b0);
        w[1] = mk(4'h2, COND_NEVER, 3'd0, 8'h01, 1'b0);
        w[2] = mk(4'h3, COND_NEVER, 3'd0, 8'h02, 1'b0);
`else
        a = '{5'd0, 5'd8, 5'd16, 5'd24, 5'd31};
        w[0] = mk(4'h1, COND_ALWAYS, 3'd7, 8'h00, 1'b0);
        w[1] = mk(4'h2, COND_ALWAYS, 3'd7, 8'h01, 1'b0);
        w[2] = mk(4'h3, COND_ALWAYS, 3'd7, 8'h02, 1'b0);
`endif
        w[3] = mk(4'h4, COND_ALWAYS, 3'd6, 8'h03, 1'b0);
        w[4] = mk(4'h6, COND_NEVER, 3'd0, 8'h1F, 1'b0);
`ifdef BACKWARD_JUMP_EN
        w[3] = mk(4'h4, COND_NEVER, 3'd0, 8'h03, 1'b0);
        w[4] = w[0];
        for (int i = 0; i < 4; i++) begin load(a[i], w[i]); push(a[i], w[i]); end
        push(5'd0, w[0]);
        n = 5;
`else
        for (int i = 0; i < 5; i++) begin load(a[i], w[i]); push(a[i], w[i]); end
        push(5'd0, w[0]);
        n = 6;
`endif
        h0 = hs_cnt;
        instr_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 60 && (hs_cnt - h0) < n; i++) tick();
        instr_ready = 1'b0;
        checks++;
        if (hs_cnt - h0 != n || sb.size() != 0) begin
            failures++;
            $display("FAIL wrap: got %0d handshakes pending=%0d, expected %0d 0", hs_cnt - h0, sb.size(), n);
        end
    endtask

    task automatic test_reset_wait();
        do_reset();
        load(0, mk(4'h1, COND_CARRY, 3'd1, 8'h00, 1'b0));
        push(0, mk(4'h1, COND_CARRY, 3'd1, 8'h00, 1'b0));
        instr_ready = 1'b1;
        pulse_start();
        wait_valid("rst_wait");
        tick(); tick();
        checks++;
        if (dut.state_q !== ST_WAIT_FLAGS) begin
            failures++;
            $display("FAIL rst_wait_pre: got state=%0d, expected %0d", dut.state_q, ST_WAIT_FLAGS);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dut.state_q !== ST_IDLE || instr_valid !== 1'b0 || pc !== 5'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait: got state=%0d valid=%b pc=%0d halted=%b, expected %0d 0 0 0",
                     dut.state_q, instr_valid, pc, halted, ST_IDLE);
        end
        flag = 4'b0011; flag_valid = 1'b1;
        tick();
        flag_valid = 1'b0; flag = '0;
        checks++;
        if (dut.state_q !== ST_IDLE || pc !== 5'd0) begin
            failures++;
            $display("FAIL idle_flag_ignored: got state=%0d pc=%0d, expected %0d 0",
                     dut.state_q, pc, ST_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jump();
        test_wait_flags(COND_ZERO, 4'b0001, 5'd3);
        test_wait_flags(COND_ZERO, 4'b0000, 5'd1);
        test_wait_flags(COND_CARRY, 4'b0010, 5'd3);
        test_wait_flags(COND_CARRY, 4'b0001, 5'd1);
        test_backpressure();
        test_prog_we_issue();
        test_start_with_we();
        test_wrap();
        test_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
